// File: rtl/dcp_run_ctrl.sv
// dcp_run_ctrl: run/step controller for the debug control unit.
// Generates clk_cpu pulses for single-step and run-to-breakpoint commands
// and stops at an instruction boundary, a breakpoint hit, a user stop or a
// hang timeout.

// One breakpoint entry: address, enable and a match against npc.
module dcp_run_bp_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        clr,
  input  logic [31:0] addr,
  input  logic [31:0] npc,
  output logic        match
);
  logic [31:0] addr_q;
  logic        en_q;

  // Clear drops only the enable and beats a simultaneous write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      en_q   <= 1'b0;
    end else if (clr) begin
      en_q   <= 1'b0;
    end else if (we) begin
      addr_q <= addr;
      en_q   <= 1'b1;
    end
  end

  assign match = en_q && (addr_q == npc);
endmodule

module dcp_run_ctrl #(
  parameter int NUM_BP   = 4,
  parameter int CLK_HALF = 2,
  parameter int MAX_CYC  = 1024,
  localparam int IW      = $clog2(NUM_BP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step_req,
  input  logic          go_req,
  input  logic          stop_req,
  input  logic          bp_we,
  input  logic [IW-1:0] bp_idx,
  input  logic [31:0]   bp_addr,
  input  logic          bp_clr,
  input  logic          pc_chk,
  input  logic [31:0]   npc,
  output logic          clk_cpu,
  output logic          busy,
  output logic          done,
  output logic [1:0]    halt_reason,
  output logic [31:0]   halt_pc,
  output logic [IW-1:0] bp_hit_idx,
  output logic [31:0]   inst_cnt
);
  localparam int PW = $clog2(MAX_CYC + 1);
  localparam int HW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam logic [HW-1:0] HLAST = HW'(CLK_HALF - 1);
  localparam logic [PW-1:0] PMAX  = PW'(MAX_CYC);

  localparam logic [1:0] R_STEP = 2'b00;
  localparam logic [1:0] R_BP   = 2'b01;
  localparam logic [1:0] R_STOP = 2'b10;
  localparam logic [1:0] R_TOUT = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_HIGH, S_LOW, S_CHECK, S_DONE} state_t;

  state_t          state;
  logic [HW-1:0]   hcnt;
  logic [PW-1:0]   pcnt;
  logic            step_mode;
  logic            stop_flag;

  logic [NUM_BP-1:0] bp_match;
  logic              hit_any;
  logic [IW-1:0]     hit_idx;

  // Breakpoint table, one entry instance per slot.
  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    dcp_run_bp_entry u_ent (
      .clk   (clk),
      .rst   (rst),
      .we    (bp_we && (bp_idx == IW'(i))),
      .clr   (bp_clr),
      .addr  (bp_addr),
      .npc   (npc),
      .match (bp_match[i])
    );
  end

  // Lowest-index matching entry wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_match[i]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Run/step sequencer; clk_cpu is a register so reset drops it at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      hcnt        <= '0;
      pcnt        <= '0;
      step_mode   <= 1'b0;
      stop_flag   <= 1'b0;
      clk_cpu     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      halt_reason <= R_STEP;
      halt_pc     <= '0;
      bp_hit_idx  <= '0;
      inst_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE && stop_req) stop_flag <= 1'b1;
      case (state)
        S_IDLE: begin
          if (step_req || go_req) begin
            step_mode <= step_req;
            inst_cnt  <= '0;
            pcnt      <= '0;
            stop_flag <= 1'b0;
            hcnt      <= '0;
            clk_cpu   <= 1'b1;
            busy      <= 1'b1;
            state     <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (hcnt == HLAST) begin
            hcnt    <= '0;
            clk_cpu <= 1'b0;
            state   <= S_LOW;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_LOW: begin
          if (hcnt == HLAST) begin
            hcnt  <= '0;
            if (pcnt != PMAX) pcnt <= pcnt + 1'b1;
            state <= S_CHECK;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (stop_flag) begin
            done        <= 1'b1;
            halt_reason <= R_STOP;
            halt_pc     <= npc;
            bp_hit_idx  <= '0;
            state       <= S_DONE;
          end else if (pc_chk) begin
            inst_cnt <= inst_cnt + 32'd1;
            pcnt     <= '0;
            if (step_mode) begin
              done        <= 1'b1;
              halt_reason <= R_STEP;
              halt_pc     <= npc;
              bp_hit_idx  <= '0;
              state       <= S_DONE;
            end else if (hit_any) begin
              done        <= 1'b1;
              halt_reason <= R_BP;
              halt_pc     <= npc;
              bp_hit_idx  <= hit_idx;
              state       <= S_DONE;
            end else begin
              clk_cpu <= 1'b1;
              state   <= S_HIGH;
            end
          end else if (pcnt == PMAX) begin
            done        <= 1'b1;
            halt_reason <= R_TOUT;
            halt_pc     <= npc;
            bp_hit_idx  <= '0;
            state       <= S_DONE;
          end else begin
            clk_cpu <= 1'b1;
            state   <= S_HIGH;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcp_run_ctrl.sv
// Self-checking bench for dcp_run_ctrl: a behavioural CPU drives pc_chk/npc
// from clk_cpu, and a pulse-level reference model predicts each command.
module tb_dcp_run_ctrl;
  localparam int NUM_BP   = 4;
  localparam int CLK_HALF = 2;
  localparam int MAX_CYC  = 8;
  localparam int IW       = $clog2(NUM_BP);
  localparam int PER      = 2 * CLK_HALF + 1;

  logic          clk = 0;
  logic          rst = 0;
  logic          step_req = 0, go_req = 0, stop_req = 0;
  logic          bp_we = 0, bp_clr = 0;
  logic [IW-1:0] bp_idx = '0;
  logic [31:0]   bp_addr = '0;
  logic          pc_chk = 0;
  logic [31:0]   npc = '0;
  logic          clk_cpu, busy, done;
  logic [1:0]    halt_reason;
  logic [31:0]   halt_pc;
  logic [IW-1:0] bp_hit_idx;
  logic [31:0]   inst_cnt;

  int pass_cnt = 0;
  int total    = 0;

  dcp_run_ctrl #(.NUM_BP(NUM_BP), .CLK_HALF(CLK_HALF), .MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .rst(rst), .step_req(step_req), .go_req(go_req),
    .stop_req(stop_req), .bp_we(bp_we), .bp_idx(bp_idx), .bp_addr(bp_addr),
    .bp_clr(bp_clr), .pc_chk(pc_chk), .npc(npc), .clk_cpu(clk_cpu),
    .busy(busy), .done(done), .halt_reason(halt_reason), .halt_pc(halt_pc),
    .bp_hit_idx(bp_hit_idx), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural CPU: each instruction takes cpu_k clk_cpu pulses, PC +4.
  logic [31:0] cpu_pc;
  int          cpu_k = 1, cpu_cyc = 0, cpu_pulses = 0;
  bit          cpu_hang = 0;
  always @(posedge clk_cpu) begin
    cpu_pulses++;
    if (cpu_hang) begin
      pc_chk = 0;
    end else begin
      cpu_cyc++;
      if (cpu_cyc >= cpu_k) begin
        cpu_cyc = 0;
        cpu_pc  = cpu_pc + 32'd4;
        npc     = cpu_pc;
        pc_chk  = 1;
      end else begin
        pc_chk = 0;
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_pc, ref_npc;
  int          ref_cyc, ref_k;
  bit          ref_hang;
  logic [31:0] ref_bp_addr [NUM_BP];
  bit          ref_bp_en   [NUM_BP];

  task automatic cpu_set(input logic [31:0] pc, input int k, input bit hang);
    cpu_pc = pc; npc = pc; pc_chk = 0; cpu_k = k; cpu_cyc = 0; cpu_hang = hang;
    ref_pc = pc; ref_npc = pc; ref_k = k; ref_cyc = 0; ref_hang = hang;
  endtask

  task automatic bp_write(input int idx, input logic [31:0] a);
    @(posedge clk); #1;
    bp_we = 1; bp_idx = IW'(idx); bp_addr = a;
    @(posedge clk); #1;
    bp_we = 0;
    ref_bp_addr[idx] = a; ref_bp_en[idx] = 1;
  endtask

  task automatic bp_clear();
    @(posedge clk); #1;
    bp_clr = 1;
    @(posedge clk); #1;
    bp_clr = 0;
    for (int i = 0; i < NUM_BP; i++) ref_bp_en[i] = 0;
  endtask

  // Predict one command pulse by pulse from the rules.
  task automatic ref_run(input bit stp, input int stop_at, output int p,
                         output logic [1:0] rsn, output logic [31:0] hpc,
                         output logic [IW-1:0] hidx, output logic [31:0] ic);
    int  since;
    bit  bnd, fin;
    p = 0; since = 0; ic = 0; rsn = 0; hidx = 0; fin = 0; hpc = 0;
    while (!fin && p < 500) begin
      p++;
      bnd = 0;
      if (!ref_hang) begin
        ref_cyc++;
        if (ref_cyc >= ref_k) begin
          ref_cyc = 0; ref_pc += 4; ref_npc = ref_pc; bnd = 1;
        end
      end
      if (since < MAX_CYC) since++;
      if (stop_at != 0 && p == stop_at) begin
        rsn = 2'b10; fin = 1;
      end else if (bnd) begin
        ic++; since = 0;
        if (stp) begin
          rsn = 2'b00; fin = 1;
        end else begin
          for (int i = 0; i < NUM_BP; i++)
            if (!fin && ref_bp_en[i] && ref_bp_addr[i] == ref_npc) begin
              rsn = 2'b01; hidx = IW'(i); fin = 1;
            end
        end
      end else if (since == MAX_CYC) begin
        rsn = 2'b11; fin = 1;
      end
      if (fin) hpc = ref_npc;
    end
  endtask

  // Issue a command, optionally inject stop_req in HIGH of pulse stop_at and
  // a step_req while busy at cycle bstep_at, then check the halt results.
  task automatic run_cmd(input string nm, input bit stp, input int stop_at,
                         input int bstep_at);
    int e_p, cnt;
    logic [1:0] e_r; logic [31:0] e_pc, e_ic; logic [IW-1:0] e_idx;
    ref_run(stp, stop_at, e_p, e_r, e_pc, e_idx, e_ic);
    @(posedge clk); #1;
    cpu_pulses = 0;
    step_req = stp; go_req = !stp;
    @(posedge clk); #1;
    step_req = 0; go_req = 0;
    cnt = 1;
    while (!done && cnt < 3000) begin
      stop_req = (stop_at != 0 && cnt == (stop_at - 1) * PER + 1);
      step_req = (cnt == bstep_at);
      @(posedge clk); #1;
      cnt++;
    end
    stop_req = 0; step_req = 0;
    total++;
    if (cnt !== e_p * PER + 1) $display("FAIL %s latency: got %0d want %0d", nm, cnt, e_p * PER + 1);
    else pass_cnt++;
    total++;
    if (cpu_pulses !== e_p) $display("FAIL %s pulses: got %0d want %0d", nm, cpu_pulses, e_p);
    else pass_cnt++;
    total++;
    if (halt_reason !== e_r) $display("FAIL %s reason: got %0d want %0d", nm, halt_reason, e_r);
    else pass_cnt++;
    total++;
    if (halt_pc !== e_pc) $display("FAIL %s halt_pc: got %h want %h", nm, halt_pc, e_pc);
    else pass_cnt++;
    total++;
    if (inst_cnt !== e_ic) $display("FAIL %s inst_cnt: got %0d want %0d", nm, inst_cnt, e_ic);
    else pass_cnt++;
    if (e_r == 2'b01) begin
      total++;
      if (bp_hit_idx !== e_idx) $display("FAIL %s bp_hit_idx: got %0d want %0d", nm, bp_hit_idx, e_idx);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    total++;
    if ({busy, done, clk_cpu} !== 3'b000)
      $display("FAIL %s post-done busy/done/clk_cpu: got %b want 000", nm, {busy, done, clk_cpu});
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1;
    #12;
    total++;
    if ({clk_cpu, busy, done, halt_reason, halt_pc, bp_hit_idx, inst_cnt} !== '0)
      $display("FAIL reset outputs: got %b/%b/%b/%b/%h/%0d/%0d want all 0",
               clk_cpu, busy, done, halt_reason, halt_pc, bp_hit_idx, inst_cnt);
    else pass_cnt++;
    @(negedge clk); rst = 0;
    for (int i = 0; i < NUM_BP; i++) begin ref_bp_en[i] = 0; ref_bp_addr[i] = 0; end
  endtask

  task automatic test_step_multi();
    cpu_set(32'h1000, 3, 0);
    run_cmd("step_k3", 1, 0, 0);
  endtask

  task automatic test_bp_single();
    bp_write(1, 32'h3010);
    cpu_set(32'h3000, 1, 0);
    run_cmd("bp_single", 0, 0, 0);
    total++;
    if (halt_pc !== 32'h3010 || bp_hit_idx !== 1 || inst_cnt !== 4)
      $display("FAIL bp_single fixed: got pc %h idx %0d ic %0d want 3010 1 4", halt_pc, bp_hit_idx, inst_cnt);
    else pass_cnt++;
  endtask

  task automatic test_bp_lowest();
    bp_clear();
    bp_write(0, 32'h3008);
    bp_write(2, 32'h3008);
    cpu_set(32'h3000, 1, 0);
    run_cmd("bp_lowest", 0, 0, 0);
  endtask

  task automatic test_clr_wins();
    bp_clear();
    @(posedge clk); #1;
    bp_clr = 1; bp_we = 1; bp_idx = 3; bp_addr = 32'h3008;
    @(posedge clk); #1;
    bp_clr = 0; bp_we = 0;
    for (int i = 0; i < NUM_BP; i++) ref_bp_en[i] = 0;
    cpu_set(32'h3000, 1, 0);
    run_cmd("clr_wins", 0, 6, 0);
  endtask

  task automatic test_stop_go();
    cpu_set(32'h4000, 2, 0);
    run_cmd("stop_go", 0, 3, 0);
  endtask

  task automatic test_stop_idle();
    @(posedge clk); #1; stop_req = 1;
    @(posedge clk); #1; stop_req = 0;
    cpu_set(32'h5000, 1, 0);
    run_cmd("stop_idle", 1, 0, 0);
  endtask

  task automatic test_timeout();
    cpu_set(32'h6000, 1, 1);
    run_cmd("timeout", 0, 0, 0);
  endtask

  task automatic test_step_busy();
    cpu_set(32'h7000, 1, 0);
    run_cmd("step_busy", 0, 4, 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NUM_BP; i++)
        if ($urandom_range(0, 1) == 1) bp_write(i, 32'h3000 + 4 * $urandom_range(1, 12));
      if ($urandom_range(0, 3) == 0) bp_clear();
      cpu_set(32'h3000, $urandom_range(1, 3), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 1) == 1)
        run_cmd("rand_step", 1, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0, 0);
      else
        run_cmd("rand_go", 0, $urandom_range(1, 30), $urandom_range(0, 6));
    end
  endtask

  task automatic test_rst_mid();
    cpu_set(32'h8000, 2, 0);
    @(posedge clk); #1; step_req = 1;
    @(posedge clk); #1; step_req = 0;
    total++;
    if (clk_cpu !== 1'b1) $display("FAIL rst_mid pre clk_cpu: got %b want 1", clk_cpu);
    else pass_cnt++;
    #2 rst = 1;
    #1;
    total++;
    if ({clk_cpu, busy, done, halt_reason, halt_pc, bp_hit_idx, inst_cnt} !== '0)
      $display("FAIL rst_mid outputs: got %b/%b/%b/%b/%h/%0d/%0d want all 0",
               clk_cpu, busy, done, halt_reason, halt_pc, bp_hit_idx, inst_cnt);
    else pass_cnt++;
    @(negedge clk); rst = 0;
    for (int i = 0; i < NUM_BP; i++) begin ref_bp_en[i] = 0; ref_bp_addr[i] = 0; end
    cpu_set(32'h8000, 1, 0);
    run_cmd("after_rst", 1, 0, 0);
  endtask

  initial begin
    cpu_set(32'h0, 1, 0);
    test_reset();
    test_step_multi();
    test_bp_single();
    test_bp_lowest();
    test_clr_wins();
    test_stop_go();
    test_stop_idle();
    test_timeout();
    test_step_busy();
    test_random();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/dcp_run_ctrl.md
# dcp_run_ctrl

Run/step controller for the debug control unit. It owns `clk_cpu` for the multi-cycle CPU and issues CPU clock pulses to carry out single-step (T) and run-to-breakpoint (G/B) commands. It stops at an instruction boundary (`pc_chk`), at a breakpoint match on `npc`, on a user stop, or on a hang timeout. It sits between the DCP command decoder, which drives the requests and breakpoint writes, and the CPU clock input.

## Interface
- `NUM_BP`, default 4: number of breakpoint entries; must be ≥ 2.
- `CLK_HALF`, default 2: `clk` cycles per `clk_cpu` half-period; must be ≥ 1.
- `MAX_CYC`, default 1024: maximum `clk_cpu` pulses without a `pc_chk` before a timeout halt.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `step_req` in 1: one-cycle pulse; execute one instruction.
- `go_req` in 1: one-cycle pulse; run until a halt condition.
- `stop_req` in 1: one-cycle pulse; halt at the next CHECK.
- `bp_we` in 1: write breakpoint entry `bp_idx`.
- `bp_idx` in clog2(NUM_BP): breakpoint entry index.
- `bp_addr` in 32: breakpoint address.
- `bp_clr` in 1: clear all breakpoint enables.
- `pc_chk` in 1: CPU is at an instruction boundary; `npc` is valid.
- `npc` in 32: next PC from the CPU.
- `clk_cpu` out 1: generated CPU clock; 0 when idle.
- `busy` out 1: a command is in progress.
- `done` out 1: one-cycle pulse at command completion.
- `halt_reason` out 2: 00 STEP, 01 BP, 10 STOP, 11 TIMEOUT.
- `halt_pc` out 32: `npc` sampled in the halting CHECK cycle.
- `bp_hit_idx` out clog2(NUM_BP): lowest matching entry; valid when `halt_reason`=BP.
- `inst_cnt` out 32: `pc_chk` events counted during the current or last command.

## Operation
- States are IDLE, HIGH, LOW, CHECK and DONE.
- **IDLE**
  - Outputs: `clk_cpu`=0, `busy`=0.
  - On `step_req` or `go_req`: latch the mode (step wins if both are asserted), clear `inst_cnt`, the pulse counter `pcnt` and the stop flag, then go to HIGH.
- **HIGH**
  - `clk_cpu`=1 for CLK_HALF cycles, then go to LOW.
- **LOW**
  - `clk_cpu`=0 for CLK_HALF cycles, then go to CHECK.
  - `pcnt` increments once per HIGH/LOW pulse.
- **CHECK**: one cycle, `clk_cpu`=0. Priority order:
  1. Stop flag set → DONE, STOP.
  2. `pc_chk`=1:
     - `inst_cnt`+1 and `pcnt` cleared.
     - Step mode → DONE, STEP.
     - Go mode with `npc` equal to any enabled entry → DONE, BP, with the lowest index in `bp_hit_idx`.
     - Otherwise → HIGH.
  3. `pcnt` = MAX_CYC → DONE, TIMEOUT.
  4. Otherwise → HIGH.
- **DONE**
  - `done`=1 for one cycle, `busy` remains 1, then go to IDLE.
  - `halt_reason`, `halt_pc`, `bp_hit_idx` and `inst_cnt` hold until the next command starts.
- `busy`=1 in HIGH, LOW, CHECK and DONE.
- Breakpoint matching only happens after at least one pulse. A `go_req` issued with the PC sitting on a breakpoint therefore always advances past it.
- `stop_req` sets the stop flag only while `busy`. It is ignored in IDLE.
- `step_req` and `go_req` are ignored while `busy`.
- Breakpoint table:
  - `bp_we` writes `bp_addr` into entry `bp_idx` and sets its enable.
  - `bp_clr` clears all enables; addresses are kept.
  - If `bp_clr` and `bp_we` arrive in the same cycle, `bp_clr` wins.
  - Writes are accepted in any state and take effect at the next CHECK.
- Counters: `inst_cnt` wraps modulo 2^32. `pcnt` is at least clog2(MAX_CYC+1) bits and saturates.

## Timing
- Reset: every output is 0, the state is IDLE, all breakpoint enables and addresses are 0, and the stop flag is 0.
- Asserting `rst` mid-command forces `clk_cpu` to 0 asynchronously. The CPU may be left mid-instruction; recovering the CPU is the owner's responsibility.
- Request in cycle t (IDLE) → HIGH from t+1.
- A pulse occupies 2·CLK_HALF cycles, and each CPU cycle costs 2·CLK_HALF+1 `clk` cycles including CHECK.
- Step of a K-CPU-cycle instruction: `done` arrives at t + K·(2·CLK_HALF+1) + 1. For CLK_HALF=2 and K=1, `done` is at t+6 and IDLE at t+7.
- A new request is accepted at the earliest in the IDLE cycle after `done`.
- `pc_chk` and `npc` are sampled only in CHECK and must be stable there. The CPU updates them on the `clk_cpu` rising edge.

## Test plan
- Reset, then CLK_HALF=2 and `step_req` with `pc_chk` high after 3 CPU pulses:
  - exactly 3 `clk_cpu` pulses, `done` at t+16, `halt_reason`=00, `inst_cnt`=1, `busy` low at t+17.
- Breakpoint 1 = 0x0000_3010, CPU advancing 4 bytes per instruction from 0x3000:
  - `go_req` → halt with BP, `bp_hit_idx`=1, `halt_pc`=0x3010, `inst_cnt`=4.
- Entries 0 and 2 both = 0x3008:
  - `bp_hit_idx`=0.
- `bp_clr` in the same cycle as a `bp_we` to 0x3008, then `go`:
  - no BP halt.
- `go` with no breakpoints, `stop_req` mid-HIGH:
  - halt at the next CHECK with reason 10.
- `stop_req` in IDLE:
  - ignored; a following `step` halts with STEP.
- `pc_chk` held 0, MAX_CYC=8:
  - exactly 8 pulses, reason 11, `inst_cnt`=0.
- `step_req` while `busy`:
  - ignored.
- `rst` during HIGH:
  - `clk_cpu`=0 immediately and all outputs 0.
